// File: rtl/vec_cache_mp.sv
// vec_cache_mp: multi-port vector register cache with clear engine; define VEC_CACHE_BYPASS_EN for same-cycle write-to-read forwarding
module vec_cache_mp #(
  parameter int WIDTH = 128,
  parameter int DATA_BITS = 32,
  parameter int CACHE_SIZE = 8,
  parameter int NUM_READ = 2,
  parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH),
  parameter int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE)
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  clear_req,
  output logic                                  clear_busy,
  input  logic [1:0]                            write_op,
  input  logic [CACHE_ADDR_SIZE-1:0]            write_addr,
  input  logic [WIDTH_ADDR_SIZE-1:0]            write_param,
  input  logic [WIDTH*DATA_BITS-1:0]            write_data,
  output logic                                  write_ready,
  input  logic [NUM_READ-1:0]                   read_en,
  input  logic [NUM_READ*CACHE_ADDR_SIZE-1:0]   read_addr,
  output logic [NUM_READ*WIDTH*DATA_BITS-1:0]   read_data,
  output logic [NUM_READ-1:0]                   read_valid,
  output logic [NUM_READ-1:0]                   read_hit
);
  localparam int VB = WIDTH * DATA_BITS;
  localparam logic [CACHE_ADDR_SIZE-1:0] LAST = CACHE_ADDR_SIZE'(CACHE_SIZE - 1);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [CACHE_ADDR_SIZE-1:0] cnt_q, cnt_d;
  logic [CACHE_SIZE-1:0] valid_q, valid_d;
  logic [VB-1:0] mem_q [CACHE_SIZE];
  logic [VB-1:0] mem_d [CACHE_SIZE];
  logic [VB-1:0] rd_data_q [NUM_READ];
  logic [VB-1:0] rd_data_d [NUM_READ];
  logic [NUM_READ-1:0] rd_valid_q, rd_valid_d, rd_hit_q, rd_hit_d, fwd;
  logic [CACHE_ADDR_SIZE-1:0] rd_addr [NUM_READ];
  logic accept;
  logic [VB-1:0] wr_vec;
  genvar g;
  generate
    for (g = 0; g < NUM_READ; g++) begin : g_port
      assign rd_addr[g] = read_addr[g*CACHE_ADDR_SIZE +: CACHE_ADDR_SIZE];
      assign read_data[g*VB +: VB] = rd_data_q[g];
    end
  endgenerate
  assign read_valid = rd_valid_q;
  assign read_hit = rd_hit_q;
  // clear FSM state register
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  // clear FSM next state: one entry wiped per cycle, leave after the last one
  always_comb
    state_d = (state_q == IDLE) ? (clear_req ? CLEAR : IDLE) : (cnt_q == LAST ? IDLE : CLEAR);
  // clear FSM outputs: writes are back-pressured while the engine runs
  always_comb begin
    clear_busy = state_q == CLEAR;
    write_ready = state_q == IDLE;
  end
  // merged entry value for an accepted write; lane writes to invalid entries start from zero
  always_comb begin
    accept = (write_op != 2'd0) && write_ready;
    wr_vec = write_op == 2'd1 ? write_data
           : write_op == 2'd3 ? {WIDTH{write_data[DATA_BITS-1:0]}}
           : valid_q[write_addr] ? mem_q[write_addr] : '0;
    if (write_op == 2'd2)
      wr_vec[write_param*DATA_BITS +: DATA_BITS] = write_data[write_param*DATA_BITS +: DATA_BITS];
  end
  // storage, valid and clear counter update; a same-edge clear overrides the write's valid bit
  always_comb begin
    mem_d = mem_q;
    valid_d = valid_q;
    cnt_d = cnt_q;
    if (accept) begin
      mem_d[write_addr] = wr_vec;
      valid_d[write_addr] = 1'b1;
    end
    if (state_q == IDLE && clear_req) begin
      valid_d = '0;
      cnt_d = '0;
    end
    if (state_q == CLEAR) begin
      mem_d[cnt_q] = '0;
      cnt_d = cnt_q + 1'b1;
    end
  end
  // forwarding select: a read of the entry being written sees the new value when enabled
  always_comb begin
`ifdef VEC_CACHE_BYPASS_EN
    for (int p = 0; p < NUM_READ; p++) fwd[p] = accept && (write_addr == rd_addr[p]);
`else
    fwd = '0;
`endif
  end
  // read ports: invalid entries read as zero; data and hit hold while a port is idle
  always_comb begin
    rd_valid_d = read_en;
    for (int p = 0; p < NUM_READ; p++) begin
      rd_hit_d[p] = read_en[p] ? (fwd[p] | valid_q[rd_addr[p]]) : rd_hit_q[p];
      rd_data_d[p] = !read_en[p] ? rd_data_q[p]
                   : fwd[p] ? wr_vec
                   : valid_q[rd_addr[p]] ? mem_q[rd_addr[p]] : '0;
    end
  end
  // control and read-port registers
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      cnt_q <= '0;
      valid_q <= '0;
      rd_valid_q <= '0;
      rd_hit_q <= '0;
      rd_data_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      rd_valid_q <= rd_valid_d;
      rd_hit_q <= rd_hit_d;
      rd_data_q <= rd_data_d;
    end
  // data array is not reset; stale contents are masked by the valid bits
  always_ff @(posedge clock)
    mem_q <= mem_d;
endmodule

// File: tb/tb_vec_cache_mp.sv
// tb_vec_cache_mp: randomized self-checking bench for vec_cache_mp against a lane-level reference model
module tb_vec_cache_mp;
  localparam int W = 128, DB = 32, CS = 8, NR = 2, AW = 3, PW = 7, VB = W * DB;
  logic clock = 1'b0, reset_n = 1'b0, clear_req = 1'b0;
  logic clear_busy, write_ready;
  logic [1:0] write_op = '0;
  logic [AW-1:0] write_addr = '0;
  logic [PW-1:0] write_param = '0;
  logic [VB-1:0] write_data = '0;
  logic [NR-1:0] read_en = '0;
  logic [NR*AW-1:0] read_addr = '0;
  logic [NR*VB-1:0] read_data;
  logic [NR-1:0] read_valid, read_hit;
  always #5 clock = ~clock;
  vec_cache_mp #(.WIDTH(W), .DATA_BITS(DB), .CACHE_SIZE(CS), .NUM_READ(NR)) dut (
    .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .clear_busy(clear_busy),
    .write_op(write_op), .write_addr(write_addr), .write_param(write_param),
    .write_data(write_data), .write_ready(write_ready), .read_en(read_en),
    .read_addr(read_addr), .read_data(read_data), .read_valid(read_valid), .read_hit(read_hit));
  logic [DB-1:0] m_mem [CS][W];
  bit m_valid [CS];
  int clr_left;
  logic [VB-1:0] exp_data [NR];
  logic [NR-1:0] exp_valid, exp_hit;
  int n_cmp = 0, n_bad = 0;
  function automatic int diff_lane(logic [VB-1:0] a, logic [VB-1:0] b);
    for (int k = 0; k < W; k++) if (a[k*DB +: DB] !== b[k*DB +: DB]) return k;
    return 0;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < CS; i++) m_valid[i] = 1'b0;
    clr_left = 0;
    exp_valid = '0;
    exp_hit = '0;
    for (int p = 0; p < NR; p++) exp_data[p] = '0;
  endtask
  task automatic rand_data();
    for (int k = 0; k < W; k++) write_data[k*DB +: DB] = $urandom();
  endtask
  // applies current inputs for one clock, advancing the model; returns #1 after the edge
  task automatic cycle();
    logic [DB-1:0] nv [W];
    bit acc;
    int a;
    acc = write_op != 2'd0 && clr_left == 0;
    for (int k = 0; k < W; k++)
      nv[k] = write_op == 2'd1 ? write_data[k*DB +: DB]
            : write_op == 2'd3 ? write_data[DB-1:0]
            : k == int'(write_param) ? write_data[k*DB +: DB]
            : m_valid[write_addr] ? m_mem[write_addr][k] : '0;
    for (int p = 0; p < NR; p++) begin
      exp_valid[p] = read_en[p];
      if (read_en[p]) begin
        a = int'(read_addr[p*AW +: AW]);
        exp_hit[p] = m_valid[a];
        for (int k = 0; k < W; k++) exp_data[p][k*DB +: DB] = m_valid[a] ? m_mem[a][k] : '0;
`ifdef VEC_CACHE_BYPASS_EN
        if (acc && a == int'(write_addr)) begin
          exp_hit[p] = 1'b1;
          for (int k = 0; k < W; k++) exp_data[p][k*DB +: DB] = nv[k];
        end
`endif
      end
    end
    if (acc) begin
      for (int k = 0; k < W; k++) m_mem[write_addr][k] = nv[k];
      m_valid[write_addr] = 1'b1;
    end
    if (clr_left > 0) clr_left--;
    else if (clear_req) begin
      for (int i = 0; i < CS; i++) m_valid[i] = 1'b0;
      clr_left = CS;
    end
    @(posedge clock);
    #1;
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if (clear_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", clear_busy); end
    n_cmp++; if (write_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", write_ready); end
    n_cmp++; if (read_valid !== 2'b00) begin n_bad++; $display("FAIL reset_rvalid: got %b want 00", read_valid); end
    n_cmp++; if (read_hit !== 2'b00) begin n_bad++; $display("FAIL reset_rhit: got %b want 00", read_hit); end
    n_cmp++; if (read_data !== '0) begin n_bad++; $display("FAIL reset_rdata: nonzero lane0 %h", read_data[DB-1:0]); end
    model_reset();
    @(negedge clock) reset_n = 1'b1;
    read_en = 2'b01;
    read_addr = {3'd0, 3'd3};
    cycle();
    read_en = '0;
    n_cmp++; if (read_valid !== 2'b01) begin n_bad++; $display("FAIL first_read_valid: got %b want 01", read_valid); end
    n_cmp++; if (read_hit[0] !== 1'b0) begin n_bad++; $display("FAIL first_read_hit: got %b want 0", read_hit[0]); end
    n_cmp++; if (read_data[VB-1:0] !== '0) begin n_bad++; $display("FAIL first_read_data: lane %0d got %h want 0", diff_lane(read_data[VB-1:0], '0), read_data[diff_lane(read_data[VB-1:0], '0)*DB +: DB]); end
  endtask
  task automatic test_full_write();
    logic [VB-1:0] want;
    for (int k = 0; k < W; k++) want[k*DB +: DB] = k;
    write_op = 2'd1; write_addr = 3'd2; write_data = want;
    cycle();
    write_op = 2'd0;
    read_en = 2'b11; read_addr = {3'd2, 3'd2};
    cycle();
    read_en = '0;
    for (int p = 0; p < NR; p++) begin
      n_cmp++; if (read_hit[p] !== 1'b1) begin n_bad++; $display("FAIL full_hit p%0d: got %b want 1", p, read_hit[p]); end
      n_cmp++; if (read_data[p*VB +: VB] !== want) begin n_bad++; $display("FAIL full_data p%0d lane %0d: got %h want %h", p, diff_lane(read_data[p*VB +: VB], want), read_data[p*VB + diff_lane(read_data[p*VB +: VB], want)*DB +: DB], want[diff_lane(read_data[p*VB +: VB], want)*DB +: DB]); end
    end
  endtask
  task automatic test_lane_broadcast();
    logic [VB-1:0] want;
    rand_data();
    write_op = 2'd2; write_addr = 3'd1; write_param = 7'd5;
    write_data[5*DB +: DB] = 32'h3F800000;
    cycle();
    write_op = 2'd0;
    read_en = 2'b01; read_addr = {3'd0, 3'd1};
    cycle();
    want = '0;
    want[5*DB +: DB] = 32'h3F800000;
    n_cmp++; if (read_hit[0] !== 1'b1) begin n_bad++; $display("FAIL lane_hit: got %b want 1", read_hit[0]); end
    n_cmp++; if (read_data[VB-1:0] !== want) begin n_bad++; $display("FAIL lane_data lane %0d: got %h want %h", diff_lane(read_data[VB-1:0], want), read_data[diff_lane(read_data[VB-1:0], want)*DB +: DB], want[diff_lane(read_data[VB-1:0], want)*DB +: DB]); end
    read_en = '0;
    rand_data();
    write_op = 2'd3; write_data[DB-1:0] = 32'h40000000;
    cycle();
    write_op = 2'd0;
    read_en = 2'b10; read_addr = {3'd1, 3'd0};
    cycle();
    read_en = '0;
    want = {W{32'h40000000}};
    n_cmp++; if (read_data[VB +: VB] !== want) begin n_bad++; $display("FAIL bcast_data lane %0d: got %h want 40000000", diff_lane(read_data[VB +: VB], want), read_data[VB + diff_lane(read_data[VB +: VB], want)*DB +: DB]); end
    n_cmp++; if (read_valid !== 2'b10) begin n_bad++; $display("FAIL bcast_valid: got %b want 10", read_valid); end
  endtask
  task automatic test_clear();
    logic [VB-1:0] held;
    int n;
    for (int i = 0; i < CS; i++) begin
      rand_data(); write_op = 2'd1; write_addr = AW'(i);
      cycle();
    end
    write_op = 2'd0;
    clear_req = 1'b1; read_en = 2'b01; read_addr = {3'd0, 3'd7};
    cycle();
    clear_req = 1'b0;
    rand_data(); held = write_data;
    write_op = 2'd1; write_addr = 3'd6;
    n = 0;
    while (clear_busy === 1'b1 && n < 20) begin
      n_cmp++; if (write_ready !== 1'b0) begin n_bad++; $display("FAIL clear_ready c%0d: got %b want 0", n, write_ready); end
      if (n > 0) begin
        n_cmp++; if (read_hit[0] !== 1'b0 || read_data[VB-1:0] !== '0) begin n_bad++; $display("FAIL clear_read c%0d: hit %b lane0 %h want hit 0 data 0", n, read_hit[0], read_data[DB-1:0]); end
      end
      n++;
      cycle();
    end
    read_en = '0;
    n_cmp++; if (n !== CS) begin n_bad++; $display("FAIL clear_len: got %0d cycles want %0d", n, CS); end
    n_cmp++; if (write_ready !== 1'b1) begin n_bad++; $display("FAIL clear_ready_after: got %b want 1", write_ready); end
    cycle();
    write_op = 2'd0;
    for (int i = 0; i < CS; i++) begin
      read_en = 2'b11; read_addr = {3'd6, AW'(i)};
      cycle();
      n_cmp++; if (read_hit[0] !== (i == 6)) begin n_bad++; $display("FAIL post_clear_hit e%0d: got %b want %b", i, read_hit[0], i == 6); end
      n_cmp++; if (read_data[VB-1:0] !== (i == 6 ? held : '0)) begin n_bad++; $display("FAIL post_clear_data e%0d lane0: got %h want %h", i, read_data[DB-1:0], i == 6 ? held[DB-1:0] : 32'h0); end
      n_cmp++; if (read_hit[1] !== 1'b1 || read_data[VB +: VB] !== held) begin n_bad++; $display("FAIL held_write e%0d: hit %b lane0 %h want hit 1 %h", i, read_hit[1], read_data[VB +: DB], held[DB-1:0]); end
    end
    read_en = '0;
  endtask
  task automatic test_same_cycle();
    logic [VB-1:0] seven;
    seven = {W{32'h40E00000}};
    rand_data();
    write_op = 2'd3; write_addr = 3'd4; write_data[DB-1:0] = 32'h40E00000;
    read_en = 2'b01; read_addr = {3'd0, 3'd4};
    cycle();
    write_op = 2'd0;
`ifdef VEC_CACHE_BYPASS_EN
    n_cmp++; if (read_hit[0] !== 1'b1) begin n_bad++; $display("FAIL same_hit: got %b want 1", read_hit[0]); end
    n_cmp++; if (read_data[VB-1:0] !== seven) begin n_bad++; $display("FAIL same_data lane0: got %h want 40e00000", read_data[DB-1:0]); end
`else
    n_cmp++; if (read_hit[0] !== 1'b0) begin n_bad++; $display("FAIL same_hit: got %b want 0", read_hit[0]); end
    n_cmp++; if (read_data[VB-1:0] !== '0) begin n_bad++; $display("FAIL same_data lane0: got %h want 0", read_data[DB-1:0]); end
`endif
    cycle();
    read_en = '0;
    n_cmp++; if (read_hit[0] !== 1'b1 || read_data[VB-1:0] !== seven) begin n_bad++; $display("FAIL next_read: hit %b lane0 %h want hit 1 40e00000", read_hit[0], read_data[DB-1:0]); end
  endtask
  task automatic test_reset_mid_clear();
    rand_data(); write_op = 2'd1; write_addr = 3'd0; cycle();
    rand_data(); write_addr = 3'd3; cycle();
    write_op = 2'd0;
    clear_req = 1'b1; cycle();
    clear_req = 1'b0;
    repeat (2) cycle();
    n_cmp++; if (clear_busy !== 1'b1) begin n_bad++; $display("FAIL midclr_busy_before: got %b want 1", clear_busy); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (clear_busy !== 1'b0) begin n_bad++; $display("FAIL midclr_busy: got %b want 0", clear_busy); end
    n_cmp++; if (write_ready !== 1'b1) begin n_bad++; $display("FAIL midclr_ready: got %b want 1", write_ready); end
    model_reset();
    @(negedge clock) reset_n = 1'b1;
    read_en = 2'b11; read_addr = {3'd3, 3'd0};
    cycle();
    read_en = '0;
    n_cmp++; if (read_hit !== 2'b00 || read_valid !== 2'b11) begin n_bad++; $display("FAIL midclr_read: hit %b valid %b want hit 00 valid 11", read_hit, read_valid); end
    n_cmp++; if (read_data !== '0) begin n_bad++; $display("FAIL midclr_data: lane0 %h want 0", read_data[DB-1:0]); end
  endtask
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      write_op = 2'($urandom_range(0, 3));
      write_addr = AW'($urandom_range(0, CS - 1));
      write_param = PW'($urandom_range(0, W - 1));
      rand_data();
      read_en = NR'($urandom_range(0, 3));
      read_addr = (NR*AW)'($urandom_range(0, 63));
      clear_req = $urandom_range(0, 29) == 0;
      cycle();
      n_cmp++; if (clear_busy !== (clr_left > 0) || write_ready !== (clr_left == 0)) begin n_bad++; $display("FAIL rnd_ctrl c%0d: busy %b ready %b want busy %b", c, clear_busy, write_ready, clr_left > 0); end
      n_cmp++; if (read_valid !== exp_valid || read_hit !== exp_hit) begin n_bad++; $display("FAIL rnd_flags c%0d: valid %b hit %b want valid %b hit %b", c, read_valid, read_hit, exp_valid, exp_hit); end
      for (int p = 0; p < NR; p++) begin
        n_cmp++; if (read_data[p*VB +: VB] !== exp_data[p]) begin n_bad++; $display("FAIL rnd_data c%0d p%0d lane %0d: got %h want %h", c, p, diff_lane(read_data[p*VB +: VB], exp_data[p]), read_data[p*VB + diff_lane(read_data[p*VB +: VB], exp_data[p])*DB +: DB], exp_data[p][diff_lane(read_data[p*VB +: VB], exp_data[p])*DB +: DB]); end
      end
    end
    write_op = 2'd0; read_en = '0; clear_req = 1'b0;
  endtask
  initial begin
    test_reset();
    test_full_write();
    test_lane_broadcast();
    test_clear();
    test_same_cycle();
    test_reset_mid_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
